// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the immediate-generation pipeline stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_C    = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } imm_res_t;

  localparam imm_res_t RES_NONE = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> 32-bit immediate/format/illegal decode.
// Compressed (RVC) decode is built only when IMM_GEN_RVC_EN is defined.
module imm_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_res_t    o_res
);

`ifdef IMM_GEN_RVC_EN
  function automatic imm_res_t decode_c(input logic [15:0] c);
    imm_res_t r;
    r     = RES_NONE;
    r.fmt = FMT_C;
    case ({c[1:0], c[15:13]})
      5'b01_000, 5'b01_010:
        r.imm = {{26{c[12]}}, c[12], c[6:2]};
      5'b01_101:
        r.imm = {{20{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
      5'b01_110, 5'b01_111:
        r.imm = {{23{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
      5'b00_010, 5'b00_110:
        r.imm = {25'b0, c[5], c[12:10], c[6], 2'b00};
      default: begin
        r.fmt     = FMT_NONE;
        r.illegal = 1'b1;
      end
    endcase
    return r;
  endfunction
`endif

  always_comb begin
    o_res = RES_NONE;
    if (i_instr[1:0] != 2'b11) begin
`ifdef IMM_GEN_RVC_EN
      o_res = decode_c(i_instr[15:0]);
`else
      o_res.illegal = 1'b1;
`endif
    end else begin
      case (i_instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR: begin
          o_res.imm = {{20{i_instr[31]}}, i_instr[31:20]};
          o_res.fmt = FMT_I;
        end
        OP_STORE: begin
          o_res.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
          o_res.fmt = FMT_S;
        end
        OP_BRANCH: begin
          o_res.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
          o_res.fmt = FMT_B;
        end
        OP_LUI, OP_AUIPC: begin
          o_res.imm = {i_instr[31:12], 12'b0};
          o_res.fmt = FMT_U;
        end
        OP_JAL: begin
          o_res.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};
          o_res.fmt = FMT_J;
        end
        OP_SYSTEM: begin
          // Only the immediate CSR forms (funct3[2]=1) carry a zimm field.
          if (i_instr[14]) begin
            o_res.imm = {27'b0, i_instr[19:15]};
            o_res.fmt = FMT_Z;
          end
        end
        OP_OP, OP_FENCE: ;
        default: o_res.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: imm_decode behind a 2-entry skid buffer.
// Optional compressed decode is enabled with the IMM_GEN_RVC_EN macro.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  imm_res_t         w_dec;
  imm_res_t         r_main;
  imm_res_t         r_skid;
  logic [TAG_W-1:0] r_main_tag;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  imm_decode u_decode (
    .i_instr (in_instr),
    .o_res   (w_dec)
  );

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          w_skid_to_main = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next state so it stays low out of reset
  // and drops the cycle after the skid entry fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= RES_NONE;
      r_main_tag <= '0;
    end else if (w_load_main) begin
      r_main     <= w_dec;
      r_main_tag <= in_tag;
    end else if (w_skid_to_main) begin
      r_main     <= r_skid;
      r_main_tag <= r_skid_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid     <= RES_NONE;
      r_skid_tag <= '0;
    end else if (w_load_skid) begin
      r_skid     <= w_dec;
      r_skid_tag <= in_tag;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_imm     = XLEN'($signed(r_main.imm));
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.illegal;
  assign out_tag     = r_main_tag;

endmodule
